// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// default latencies and the controller state type.
package mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing the HI/LO pair.
// Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        signed_div;
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] divisor;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        // Low 64 bits of the sign-extended product equal the signed product.
        prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
        prod_u = {32'd0, rs_data} * {32'd0, rt_data};

        signed_div  = (op == MDU_DIV);
        rs_neg      = signed_div & rs_data[31];
        rt_neg      = signed_div & rt_data[31];
        rs_mag      = rs_neg ? (~rs_data + 32'd1) : rs_data;
        rt_mag      = rt_neg ? (~rt_data + 32'd1) : rt_data;
        div_by_zero = is_div_op(op) && (rt_data == 32'd0);
        divisor     = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
        quot_u      = rs_mag / divisor;
        rem_u       = rs_mag % divisor;
        quot        = (rs_neg ^ rt_neg) ? (~quot_u + 32'd1) : quot_u;
        rem         = rs_neg ? (~rem_u + 32'd1) : rem_u;

        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            MDU_MULT:  {hi_res, lo_res} = prod_s;
            MDU_MULTU: {hi_res, lo_res} = prod_u;
            MDU_DIV,
            MDU_DIVU: begin
                hi_res = rem;
                lo_res = quot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO register file and latency sequencer for the E-stage MDU.
// State | meaning
// IDLE  | accepting ops; MTHI/MTLO write immediately
// BUSY  | result pending, counting down to the HI/LO commit
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_dbz_q, pend_dbz_d;
    logic             done_q, done_d;

    logic [31:0] hi_res;
    logic [31:0] lo_res;
    logic        div_by_zero;

    mdu_arith u_arith (
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .hi_res      (hi_res),
        .lo_res      (lo_res),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        pend_hi_d  = pend_hi_q;
        pend_lo_d  = pend_lo_q;
        pend_dbz_d = pend_dbz_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            pend_hi_d  = hi_res;
                            pend_lo_d  = lo_res;
                            pend_dbz_d = div_by_zero;
                            cnt_d      = is_div_op(op) ? DIV_LAT : MULT_LAT;
                            state_d    = ST_BUSY;
                        end
                        MDU_MTHI: hi_d = rs_data;
                        MDU_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Divide-by-zero still spends its latency but leaves HI/LO alone.
                    if (!pend_dbz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            pend_hi_q  <= '0;
            pend_lo_q  <= '0;
            pend_dbz_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            pend_hi_q  <= pend_hi_d;
            pend_lo_q  <= pend_lo_d;
            pend_dbz_q <= pend_dbz_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected HI/LO and latency queued at issue,
// popped and compared when the unit signals completion.
module tb_mdu_hilo;
    import mdu_pkg::*;

    localparam int T_MULT = 5;
    localparam int T_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    mdu_hilo #(
        .MULT_CYCLES (T_MULT),
        .DIV_CYCLES  (T_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("done_busy_excl", 64'(done & busy), 64'd0);
            chk("start_while_busy", 64'(start & busy), 64'd0);
        end
    end

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb_, q, r;
        logic [63:0] p;
        e.hi = m_hi;
        e.lo = m_lo;
        e.cycles = (o == MDU_MULT || o == MDU_MULTU) ? T_MULT : T_DIV;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        case (o)
            MDU_MULT: begin
                q = sa * sb_;
                p = q;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MDU_DIV: if (b != 32'd0) begin
                q = sa / sb_;
                r = sa % sb_;
                e.lo = q[31:0];
                e.hi = r[31:0];
            end
            MDU_DIVU: if (b != 32'd0) begin
                e.lo = a / b;
                e.hi = a % b;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        sb.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0; op = MDU_NONE;
        chk({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, 64'(n), 64'(e.cycles));
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_hilo"}, {hi, lo}, {e.hi, e.lo});
        m_hi = e.hi;
        m_lo = e.lo;
        @(posedge clk); #1;
        chk({tag, "_done_off"}, 64'(done), 64'd0);
    endtask

    task automatic move_to(input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a;
        @(posedge clk); #1;
        start = 1'b0; op = MDU_NONE;
        if (o == MDU_MTHI) m_hi = a;
        if (o == MDU_MTLO) m_lo = a;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          seen_done;

        #12;
        chk("rst_outputs", {30'd0, busy, done, hi}, 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // MTHI then MTLO on back-to-back edges
        @(negedge clk);
        start = 1'b1; op = MDU_MTHI; rs_data = 32'h1234_5678;
        @(posedge clk); #1;
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_bd", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        op = MDU_MTLO; rs_data = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0; op = MDU_NONE;
        chk("mtlo_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        chk("mtlo_bd", {62'd0, busy, done}, 64'd0);
        m_hi = 32'h1234_5678;
        m_lo = 32'h9ABC_DEF0;

        // NONE and reserved op must be inert
        move_to(MDU_NONE, 32'hDEAD_BEEF);
        move_to(3'd7, 32'hDEAD_BEEF);
        chk("nop_hilo", {hi, lo}, {m_hi, m_lo});
        chk("nop_busy", 64'(busy), 64'd0);

        move_to(MDU_MTHI, 32'h0000_00AA);
        move_to(MDU_MTLO, 32'h0000_0055);
        run_op("divu_zero", MDU_DIVU, 32'h1234_0000, 32'd0);
        chk("divu_zero_const", {hi, lo}, 64'h0000_00AA_0000_0055);
        run_op("div_zero", MDU_DIV, 32'h8000_0000, 32'd0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("div_pos_neg", MDU_DIV, 32'd7, 32'hFFFF_FFFE);

        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) rb = rb & 32'h0000_00FF;
            run_op("rnd", ro, ra, rb);
        end

        // Reset during the third busy cycle aborts the multiply
        move_to(MDU_MTHI, 32'h5555_AAAA);
        move_to(MDU_MTLO, 32'hAAAA_5555);
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; rs_data = 32'd100; rt_data = 32'd200;
        @(posedge clk); #1;
        start = 1'b0; op = MDU_NONE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_busy_pre", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_async", {30'd0, busy, done, hi}, 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        chk("abort_no_commit", {hi, lo}, 64'd0);
        chk("abort_no_done", 64'(seen_done), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        run_op("post_abort", MDU_MULTU, 32'h0001_0000, 32'h0001_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
